// File: rtl/round_dither_expand.sv
// round_dither_expand
// Refills the low NBITS of a round-to-even quantised word with LFSR dither
// centred on the quantisation bin, clamping negative results to zero.
// One output register plus one skid register; din_ready is a flop output.
module round_dither_expand #(
    parameter int          DIN   = 16,
    parameter int          NBITS = 4,
    parameter logic [31:0] SEED  = 32'hACE10001
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    input  logic           dither_en,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DIN-1:0] dout_data
);

    // Galois feedback taps for x^32+x^22+x^2+x+1
    localparam logic [31:0]    LFSR_MASK = 32'h80200003;
    // Keeps only the bits that survived quantisation
    localparam logic [DIN-1:0] Q_MASK    = {DIN{1'b1}} << NBITS;
    // Half a quantisation bin, in the widened arithmetic width
    localparam logic [DIN:0]   HALF      = {{DIN{1'b0}}, 1'b1} << (NBITS - 1);

    logic [31:0]    lfsr_reg;
    logic [31:0]    lfsr_next;
    logic           out_valid_reg;
    logic [DIN-1:0] out_data_reg;
    logic           skid_valid_reg;
    logic [DIN-1:0] skid_data_reg;

    logic           accept;
    logic           out_free;
    logic [DIN-1:0] q_word;
    logic [DIN:0]   q_ext;
    logic [DIN:0]   r_ext;
    logic [DIN:0]   y_ext;
    logic [DIN-1:0] word_next;

    // Right-shifting Galois step: bit 0 falls out and, when set, folds the
    // mask back in; the top bit receives the feedback directly.
    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_lfsr
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
        end
    endgenerate
    assign lfsr_next[31] = LFSR_MASK[31] & lfsr_reg[0];

    // din_ready depends only on skid occupancy, so it is a pure flop output
    assign din_ready  = !skid_valid_reg;
    assign accept     = din_valid && !skid_valid_reg;
    assign out_free   = !out_valid_reg || dout_ready;
    assign dout_valid = out_valid_reg;
    assign dout_data  = out_data_reg;

    // Reconstruct the accepted word: q - h + r in DIN+1 bits, clamp on borrow
    always_comb begin
        q_word    = din_data & Q_MASK;
        q_ext     = {1'b0, q_word};
        r_ext     = {{(DIN + 1 - NBITS){1'b0}}, lfsr_reg[NBITS-1:0]};
        y_ext     = q_ext - HALF + r_ext;
        word_next = q_word;
        if (dither_en) begin
            word_next = y_ext[DIN] ? '0 : y_ext[DIN-1:0];
        end
    end

    // LFSR advances only on an input handshake, so stalls do not consume dither
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= SEED;
        end else if (accept) begin
            lfsr_reg <= lfsr_next;
        end
    end

    // Output register with skid: skid drains first, new words bypass the
    // skid whenever the output register can take them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            if (skid_valid_reg) begin
                // Output is necessarily full here; no new word is accepted
                if (dout_ready) begin
                    out_data_reg   <= skid_data_reg;
                    skid_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                if (out_free) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= word_next;
                end else begin
                    skid_valid_reg <= 1'b1;
                    skid_data_reg  <= word_next;
                end
            end else if (dout_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule
